raster_scheduler: RTL and testbench

Triangle scheduler that sits between triangle producers (vertex/setup logic or a host port) and `rasterizer_unit`. It buffers submitted triangles in a small FIFO and issues them one at a time to the rasterizer using its start/done handshake. It holds frame-buffer `gpu_access` for the whole frame and emits a single-cycle `swap` pulse once the frame's last triangle has been rasterized.

---
 rtl/gpu_pkg.sv | 26 ++
 rtl/tri_fifo.sv | 61 ++++++
 rtl/raster_scheduler.sv | 137 +++++++++++++
 tb/tb_raster_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared GPU types: vertex layout, triangle FIFO entry and the
// scheduler state encoding used by raster_scheduler.
package gpu_pkg;

    // One vertex: three IEEE-754 singles, x in the low word.
    typedef struct packed {
        logic [31:0] z;
        logic [31:0] y;
        logic [31:0] x;
    } vertex_t;

    typedef struct packed {
        vertex_t p1;
        vertex_t p2;
        vertex_t p3;
        logic    last;
    } tri_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_SWAP  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/tri_fifo.sv
// Register-based synchronous FIFO of triangle entries.
// Ports: i_push/i_data write, i_pop retires the head,
// o_head / o_head_nxt expose the first two entries,
// o_full / o_empty / o_level report occupancy.
module tri_fifo
    import gpu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       areset,
    input  logic       i_push,
    input  tri_entry_t i_data,
    input  logic       i_pop,
    output tri_entry_t o_head,
    output tri_entry_t o_head_nxt,
    output logic       o_full,
    output logic       o_empty,
    output logic [AW:0] o_level
);

    tri_entry_t    r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;
    logic [AW-1:0] w_rd_nxt;

    // DEPTH is a power of two, so pointers wrap naturally.
    assign w_rd_nxt = r_rd + AW'(1);

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push)
                r_wr <= r_wr + AW'(1);
            if (i_pop)
                r_rd <= w_rd_nxt;
            if (i_push && !i_pop)
                r_cnt <= r_cnt + (AW+1)'(1);
            else if (i_pop && !i_push)
                r_cnt <= r_cnt - (AW+1)'(1);
        end
    end

    // Payload storage needs no reset; occupancy guards reads.
    always_ff @(posedge clk) begin
        if (i_push)
            r_mem[r_wr] <= i_data;
    end

    assign o_head     = r_mem[r_rd];
    assign o_head_nxt = r_mem[w_rd_nxt];
    assign o_full     = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty    = (r_cnt == '0);
    assign o_level    = r_cnt;

endmodule

// File: rtl/raster_scheduler.sv
// Buffers triangles and issues them one at a time to the rasterizer,
// holding frame-buffer access for the frame and pulsing swap at its end.
// Ports: tri_* producer handshake, ru_* rasterizer start/done + vertices,
// gpu_access/swap frame control, busy/level/tri_count status.
module raster_scheduler
    import gpu_pkg::*;
#(
    parameter  int DEPTH      = 4,
    parameter  int START_HOLD = 3,
    localparam int LW         = $clog2(DEPTH) + 1,
    localparam int HW         = (START_HOLD > 1) ? $clog2(START_HOLD) : 1
) (
    input  logic          clk,
    input  logic          areset,
    input  logic          tri_valid,
    output logic          tri_ready,
    input  vertex_t       tri_p1,
    input  vertex_t       tri_p2,
    input  vertex_t       tri_p3,
    input  logic          tri_last,
    output logic          ru_start,
    output vertex_t       ru_p1,
    output vertex_t       ru_p2,
    output vertex_t       ru_p3,
    input  logic          ru_done,
    output logic          gpu_access,
    output logic          swap,
    output logic          busy,
    output logic [LW-1:0] level,
    output logic [15:0]   tri_count
);

    sched_state_e  r_state;
    logic [HW-1:0] r_hold;
    logic          r_open;
    logic [15:0]   r_cnt;
    vertex_t       r_p1;
    vertex_t       r_p2;
    vertex_t       r_p3;

    tri_entry_t    w_in;
    tri_entry_t    w_head;
    tri_entry_t    w_head_nxt;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [LW-1:0] w_level;
    logic          w_hold_last;

    assign w_in        = '{p1: tri_p1, p2: tri_p2, p3: tri_p3, last: tri_last};
    assign w_push      = tri_valid && !w_full;
    assign w_pop       = (r_state == ST_WAIT) && ru_done;
    assign w_hold_last = (r_hold == HW'(START_HOLD - 1));

    tri_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .areset     (areset),
        .i_push     (w_push),
        .i_data     (w_in),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_head_nxt (w_head_nxt),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_level    (w_level)
    );

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state <= ST_IDLE;
            r_hold  <= '0;
            r_open  <= 1'b0;
            r_cnt   <= '0;
            r_p1    <= '0;
            r_p2    <= '0;
            r_p3    <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_p1    <= w_head.p1;
                        r_p2    <= w_head.p2;
                        r_p3    <= w_head.p3;
                        r_open  <= 1'b1;
                        r_hold  <= '0;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_hold_last) begin
                        r_hold  <= '0;
                        r_state <= ST_WAIT;
                    end else begin
                        r_hold <= r_hold + HW'(1);
                    end
                end
                ST_WAIT: begin
                    if (ru_done) begin
                        if (r_cnt != 16'hFFFF)
                            r_cnt <= r_cnt + 16'd1;
                        if (w_head.last) begin
                            r_state <= ST_SWAP;
                        end else if (w_level > LW'(1)) begin
                            // Entry behind the popped head goes out directly.
                            r_p1    <= w_head_nxt.p1;
                            r_p2    <= w_head_nxt.p2;
                            r_p3    <= w_head_nxt.p3;
                            r_hold  <= '0;
                            r_state <= ST_START;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_SWAP: begin
                    r_open  <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign tri_ready  = !w_full;
    assign ru_start   = (r_state == ST_START);
    assign ru_p1      = r_p1;
    assign ru_p2      = r_p2;
    assign ru_p3      = r_p3;
    assign gpu_access = r_open && (r_state != ST_SWAP);
    assign swap       = (r_state == ST_SWAP);
    assign busy       = (r_state != ST_IDLE) || !w_empty;
    assign level      = w_level;
    assign tri_count  = r_cnt;

endmodule

// File: tb/tb_raster_scheduler.sv
// Testbench for raster_scheduler: directed scenarios plus random
// traffic, all checked every cycle against a queue-based reference.
module tb_raster_scheduler;
    import gpu_pkg::*;

    localparam int DEPTH = 4;
    localparam int HOLD  = 3;

    logic        clk = 1'b0;
    logic        areset;
    logic        tri_valid;
    logic        tri_ready;
    logic [95:0] tri_p1, tri_p2, tri_p3;
    logic        tri_last;
    logic        ru_start;
    logic [95:0] ru_p1, ru_p2, ru_p3;
    logic        ru_done;
    logic        gpu_access;
    logic        swap;
    logic        busy;
    logic [2:0]  level;
    logic [15:0] tri_count;

    raster_scheduler #(.DEPTH(DEPTH), .START_HOLD(HOLD)) dut (
        .clk        (clk),
        .areset     (areset),
        .tri_valid  (tri_valid),
        .tri_ready  (tri_ready),
        .tri_p1     (tri_p1),
        .tri_p2     (tri_p2),
        .tri_p3     (tri_p3),
        .tri_last   (tri_last),
        .ru_start   (ru_start),
        .ru_p1      (ru_p1),
        .ru_p2      (ru_p2),
        .ru_p3      (ru_p3),
        .ru_done    (ru_done),
        .gpu_access (gpu_access),
        .swap       (swap),
        .busy       (busy),
        .level      (level),
        .tri_count  (tri_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [95:0] p1;
        logic [95:0] p2;
        logic [95:0] p3;
        logic        last;
    } ent_t;

    // Reference: a queue of stored triangles plus the phase of the
    // triangle in flight (start cycles left / waiting / swapping).
    ent_t        q[$];
    int          m_start;
    bit          m_wait;
    bit          m_swap;
    bit          m_open;
    int          m_cnt;
    logic [95:0] m_p1, m_p2, m_p3;

    int n_chk  = 0;
    int n_pass = 0;

    localparam logic [95:0] VA = {32'h3f800000, 32'h428a0000, 32'h428a0000};
    localparam logic [95:0] VB = {32'h3f800000, 32'h43290000, 32'h428a0000};
    localparam logic [95:0] VC = {32'h3f800000, 32'h428a0000, 32'h43290000};

    task automatic chk(input string tag, input logic [95:0] act,
                       input logic [95:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h want %h", tag, act, exp);
    endtask

    function automatic logic [95:0] rnd96();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        q.delete();
        m_start = 0;
        m_wait  = 0;
        m_swap  = 0;
        m_open  = 0;
        m_cnt   = 0;
        m_p1    = '0;
        m_p2    = '0;
        m_p3    = '0;
    endtask

    task automatic model_issue(input ent_t e);
        m_p1    = e.p1;
        m_p2    = e.p2;
        m_p3    = e.p3;
        m_start = HOLD;
    endtask

    // Advance the reference by one clock edge using the inputs
    // that were present at that edge.
    task automatic model_step();
        ent_t e;
        ent_t h;
        bit   push;
        push   = tri_valid && (q.size() < DEPTH);
        e.p1   = tri_p1;
        e.p2   = tri_p2;
        e.p3   = tri_p3;
        e.last = tri_last;
        if (m_swap) begin
            m_swap = 0;
            m_open = 0;
            m_cnt  = 0;
        end else if (m_start > 0) begin
            m_start--;
            if (m_start == 0)
                m_wait = 1;
        end else if (m_wait) begin
            if (ru_done) begin
                h      = q.pop_front();
                m_wait = 0;
                if (m_cnt < 65535)
                    m_cnt++;
                if (h.last)
                    m_swap = 1;
                else if (q.size() > 0)
                    model_issue(q[0]);
            end
        end else if (q.size() > 0) begin
            m_open = 1;
            model_issue(q[0]);
        end
        if (push)
            q.push_back(e);
    endtask

    task automatic compare_all();
        bit m_busy;
        m_busy = (m_start > 0) || m_wait || m_swap || (q.size() > 0);
        chk("ready", 96'(tri_ready), 96'(q.size() < DEPTH));
        chk("start", 96'(ru_start), 96'(m_start > 0));
        chk("p1", ru_p1, m_p1);
        chk("p2", ru_p2, m_p2);
        chk("p3", ru_p3, m_p3);
        chk("gpu", 96'(gpu_access), 96'(m_open && !m_swap));
        chk("swap", 96'(swap), 96'(m_swap));
        chk("busy", 96'(busy), 96'(m_busy));
        chk("level", 96'(level), 96'(q.size()));
        chk("count", 96'(tri_count), 96'(m_cnt));
    endtask

    // Called at a falling edge; drives inputs for the next rising edge
    // and checks all outputs at the following falling edge.
    task automatic step(input bit v, input logic [95:0] a,
                        input logic [95:0] b, input logic [95:0] c,
                        input bit last, input bit done);
        tri_valid = v;
        tri_p1    = a;
        tri_p2    = b;
        tri_p3    = c;
        tri_last  = last;
        ru_done   = done;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n, input bit done);
        for (int i = 0; i < n; i++)
            step(1'b0, '0, '0, '0, 1'b0, done);
    endtask

    task automatic push(input bit last, input bit done);
        step(1'b1, rnd96(), rnd96(), rnd96(), last, done);
    endtask

    int starts;
    int swaps;
    int peak;
    int drops;
    bit seen;

    initial begin
        areset    = 1'b1;
        tri_valid = 1'b0;
        tri_p1    = '0;
        tri_p2    = '0;
        tri_p3    = '0;
        tri_last  = 1'b0;
        ru_done   = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        compare_all();
        chk("rst_ready", 96'(tri_ready), 96'(1));
        chk("rst_level", 96'(level), 96'(0));
        areset = 1'b0;

        // Single triangle, frame of one.
        step(1'b1, VA, VB, VC, 1'b1, 1'b0);
        chk("t1_lat", 96'(ru_start), 96'(0));
        starts = 0;
        for (int i = 0; i < HOLD; i++) begin
            step(1'b0, '0, '0, '0, 1'b0, 1'b0);
            if (ru_start)
                starts++;
            if (i == 0) begin
                chk("t1_p1", ru_p1, VA);
                chk("t1_gpu", 96'(gpu_access), 96'(1));
            end
        end
        chk("t1_starts", 96'(starts), 96'(HOLD));
        idle(10, 1'b0);
        chk("t1_gpu_wait", 96'(gpu_access), 96'(1));
        idle(1, 1'b1);
        chk("t1_swap", 96'(swap), 96'(1));
        chk("t1_gpu_swap", 96'(gpu_access), 96'(0));
        chk("t1_cnt1", 96'(tri_count), 96'(1));
        idle(1, 1'b0);
        chk("t1_swap_end", 96'(swap), 96'(0));
        chk("t1_cnt0", 96'(tri_count), 96'(0));
        idle(3, 1'b0);

        // Fill while the rasterizer stalls.
        push(1'b0, 1'b0);
        push(1'b0, 1'b0);
        push(1'b0, 1'b0);
        push(1'b1, 1'b0);
        chk("fill_level", 96'(level), 96'(4));
        chk("fill_ready", 96'(tri_ready), 96'(0));
        push(1'b0, 1'b0);
        chk("fill_5th", 96'(level), 96'(4));
        idle(4, 1'b0);
        idle(1, 1'b1);
        chk("fill_pop_level", 96'(level), 96'(3));
        chk("fill_pop_ready", 96'(tri_ready), 96'(1));
        idle(30, 1'b1);
        chk("fill_drained", 96'(level), 96'(0));

        // Back-to-back frame of three.
        push(1'b0, 1'b0);
        push(1'b0, 1'b0);
        push(1'b1, 1'b0);
        swaps = 0;
        peak  = 0;
        drops = 0;
        seen  = 0;
        for (int i = 0; i < 24; i++) begin
            step(1'b0, '0, '0, '0, 1'b0, 1'b1);
            if (ru_start)
                seen = 1;
            if (swap)
                swaps++;
            if (seen && swaps == 0 && !gpu_access)
                drops++;
            if (int'(tri_count) > peak)
                peak = int'(tri_count);
        end
        chk("b2b_swaps", 96'(swaps), 96'(1));
        chk("b2b_peak", 96'(peak), 96'(3));
        chk("b2b_drops", 96'(drops), 96'(0));

        // Push and pop on the same edge at level 2.
        push(1'b0, 1'b0);
        push(1'b0, 1'b0);
        idle(4, 1'b0);
        chk("sim_pre", 96'(level), 96'(2));
        push(1'b1, 1'b1);
        chk("sim_level", 96'(level), 96'(2));
        idle(25, 1'b1);

        // Spurious done in IDLE and START.
        idle(3, 1'b1);
        chk("spur_idle_cnt", 96'(tri_count), 96'(0));
        push(1'b1, 1'b1);
        idle(1, 1'b1);
        chk("spur_start", 96'(ru_start), 96'(1));
        chk("spur_start_lvl", 96'(level), 96'(1));
        chk("spur_start_cnt", 96'(tri_count), 96'(0));
        idle(10, 1'b1);

        // Asynchronous reset while waiting with two entries queued.
        push(1'b0, 1'b0);
        push(1'b1, 1'b0);
        idle(5, 1'b0);
        chk("rw_level", 96'(level), 96'(2));
        #2;
        areset = 1'b1;
        #1;
        model_reset();
        compare_all();
        chk("rw_gpu", 96'(gpu_access), 96'(0));
        @(negedge clk);
        areset = 1'b0;
        swaps = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, '0, '0, '0, 1'b0, 1'b1);
            if (swap)
                swaps++;
        end
        chk("rw_noswap", 96'(swaps), 96'(0));

        // Random traffic.
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 1) == 1, rnd96(), rnd96(), rnd96(),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 9) < 3);
        for (int i = 0; i < 40; i++)
            step(1'b0, '0, '0, '0, 1'b0, $urandom_range(0, 1) == 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
